// File: rtl/ldst_request_sequencer_pkg.sv
// Shared constants and types for the load/store request sequencer.
package ldst_request_sequencer_pkg;

   localparam int N_CORES_DEF = 4;
   localparam int ADDR_W_DEF  = 16;
   localparam int DATA_W_DEF  = 16;

   localparam logic [1:0] LDST_IDLE  = 2'd0;
   localparam logic [1:0] LDST_ISSUE = 2'd1;
   localparam logic [1:0] LDST_WAIT  = 2'd2;
   localparam logic [1:0] LDST_DONE  = 2'd3;

   typedef enum logic {
      OP_LOAD  = 1'b0,
      OP_STORE = 1'b1
   } ldst_op_e;

   // Load has priority when both commands arrive together.
   function automatic ldst_op_e decode_op(input logic ld);
      return ld ? OP_LOAD : OP_STORE;
   endfunction

endpackage

// File: rtl/ldst_request_sequencer_if.sv
// Shared-memory request bus between a core-side sequencer and the memory controller.
interface ldst_request_sequencer_if #(
   parameter int N_CORES = 4,
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16
);
   logic                        MRead;
   logic                        MWrite;
   logic                        MReady;
   logic [N_CORES-1:0]          en;
   logic [N_CORES*ADDR_W-1:0]   addr;
   logic [N_CORES*DATA_W-1:0]   data;
   logic [N_CORES*DATA_W-1:0]   q;

   modport master (output MRead, MWrite, en, addr, data, input MReady, q);
   modport slave  (input MRead, MWrite, en, addr, data, output MReady, q);
endinterface

// File: rtl/ldst_request_sequencer_watchdog.sv
// ldst_watchdog: down-counter that flags a stalled WAIT after TIMEOUT_CYC cycles.
module ldst_watchdog #(
   parameter int TIMEOUT_CYC = 64
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic run,
   output logic expired
);
   localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] cnt;

   // Loaded on the edge entering WAIT, so terminal count lands on the last allowed cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= LOAD_VAL;
      end else if (run && cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign expired = run && (cnt == '0);
endmodule

// File: rtl/ldst_request_sequencer.sv
// Core-side initiator for the MRead/MWrite/MReady shared-memory handshake.
// Define LDST_TIMEOUT_EN to add the WAIT watchdog and the timeout_err output.
//
// state      | meaning
// LDST_IDLE  | waiting for start_ld / start_st
// LDST_ISSUE | one-cycle MRead or MWrite pulse
// LDST_WAIT  | holding request until MReady (or watchdog expiry)
// LDST_DONE  | one-cycle done pulse, back to idle
module ldst_request_sequencer
   import ldst_request_sequencer_pkg::*;
#(
   parameter int N_CORES = N_CORES_DEF,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF
`ifdef LDST_TIMEOUT_EN
   ,parameter int TIMEOUT_CYC = 64
`endif
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start_ld,
   input  logic                      start_st,
   input  logic [N_CORES-1:0]        en_in,
   input  logic [N_CORES*ADDR_W-1:0] addr_in,
   input  logic [N_CORES*DATA_W-1:0] wdata_in,
   ldst_request_sequencer_if.master  mem,
   output logic [N_CORES*DATA_W-1:0] rdata_out,
   output logic                      busy,
   output logic                      done
`ifdef LDST_TIMEOUT_EN
   ,output logic                     timeout_err
`endif
);

   logic [1:0]                state;
   logic [1:0]                state_nxt;
   ldst_op_e                  op;
   logic [N_CORES-1:0]        en_q;
   logic [N_CORES*ADDR_W-1:0] addr_q;
   logic [N_CORES*DATA_W-1:0] data_q;
   logic [N_CORES*DATA_W-1:0] rdata_q;
   logic                      accept;
   logic                      ready_hit;
   logic                      expired;

   assign accept    = (state == LDST_IDLE) && (start_ld || start_st);
   assign ready_hit = (state == LDST_WAIT) && mem.MReady;

`ifdef LDST_TIMEOUT_EN
   ldst_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .load    (state == LDST_ISSUE),
      .run     (state == LDST_WAIT),
      .expired (expired)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         timeout_err <= 1'b0;
      end else if (accept) begin
         timeout_err <= 1'b0;
      end else if (expired && !ready_hit) begin
         timeout_err <= 1'b1;
      end
   end
`else
   assign expired = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         LDST_IDLE:  if (start_ld || start_st) state_nxt = (en_in == '0) ? LDST_DONE : LDST_ISSUE;
         LDST_ISSUE: state_nxt = LDST_WAIT;
         LDST_WAIT:  if (ready_hit || expired) state_nxt = LDST_DONE;
         LDST_DONE:  state_nxt = LDST_IDLE;
         default:    state_nxt = LDST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= LDST_IDLE;
         op     <= OP_LOAD;
         en_q   <= '0;
         addr_q <= '0;
         data_q <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            op     <= decode_op(start_ld);
            en_q   <= en_in;
            addr_q <= addr_in;
            data_q <= wdata_in;
         end
      end
   end

   // Only enabled lanes of a load take the controller's data; the rest keep history.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdata_q <= '0;
      end else if (ready_hit && op == OP_LOAD) begin
         for (int i = 0; i < N_CORES; i++) begin
            if (en_q[i]) rdata_q[i*DATA_W +: DATA_W] <= mem.q[i*DATA_W +: DATA_W];
         end
      end
   end

   assign mem.MRead  = (state == LDST_ISSUE) && (op == OP_LOAD);
   assign mem.MWrite = (state == LDST_ISSUE) && (op == OP_STORE);
   assign mem.en     = en_q;
   assign mem.addr   = addr_q;
   assign mem.data   = data_q;
   assign rdata_out  = rdata_q;
   assign busy       = (state != LDST_IDLE);
   assign done       = (state == LDST_DONE);

endmodule
